// File: rtl/flash_cmd_sequencer_if.sv
// CPU bus inputs and sequencer status outputs for the PRG flash
// command sequencer.
interface flash_cmd_sequencer_if;
    logic        romsel;
    logic        cpu_rw_in;
    logic [14:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;
    logic        prg_write_enabled;
    logic        flash_we_allow;
    logic        flash_busy;
    logic        id_mode;
    logic        seq_error;
    logic [7:0]  last_cmd;
    logic [15:0] prog_count;

    modport master (
        output romsel,
        output cpu_rw_in,
        output cpu_addr_in,
        output cpu_data_in,
        output prg_write_enabled,
        input  flash_we_allow,
        input  flash_busy,
        input  id_mode,
        input  seq_error,
        input  last_cmd,
        input  prog_count
    );

    modport slave (
        input  romsel,
        input  cpu_rw_in,
        input  cpu_addr_in,
        input  cpu_data_in,
        input  prg_write_enabled,
        output flash_we_allow,
        output flash_busy,
        output id_mode,
        output seq_error,
        output last_cmd,
        output prog_count
    );
endinterface

// File: rtl/flash_cmd_sequencer.sv
// JEDEC command tracker for PRG flash: unlock/command decoding,
// embedded program/erase busy timing and flash write gating.
module flash_cmd_sequencer #(
    parameter logic [14:0] CMD_ADDR1         = 15'h0AAA,
    parameter logic [14:0] CMD_ADDR2         = 15'h0555,
    parameter logic [14:0] ADDR_MASK         = 15'h0FFF,
    parameter logic [7:0]  GAP_CYCLES        = 8'd64,
    parameter logic [26:0] PROG_CYCLES       = 27'd40,
    parameter logic [26:0] ERASE_CYCLES      = 27'd1250000,
    parameter logic [26:0] CHIP_ERASE_CYCLES = 27'd72000000
) (
    input logic                  m2,
    input logic                  not_reset,
    flash_cmd_sequencer_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_U1,
        S_U2,
        S_PROG,
        S_E80,
        S_EU1,
        S_EU2,
        S_ID,
        S_BUSY
    } state_t;

    state_t      state_q;
    logic [26:0] busy_q;
    logic [26:0] busy_d;
    logic [7:0]  gap_q;
    logic [7:0]  gap_d;
    logic [7:0]  last_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        err_q;

    logic        romw;
    logic        a1;
    logic        a2;
    logic        f0;
    logic        in_seq;
    logic [7:0]  d;

    assign d      = bus.cpu_data_in;
    assign romw   = ~bus.romsel & ~bus.cpu_rw_in;
    assign a1     = (bus.cpu_addr_in & ADDR_MASK) == CMD_ADDR1;
    assign a2     = (bus.cpu_addr_in & ADDR_MASK) == CMD_ADDR2;
    assign f0     = d == 8'hF0;
    assign in_seq = state_q inside {S_U1, S_U2, S_PROG,
                                    S_E80, S_EU1, S_EU2};

    assign busy_d = busy_q - 27'd1;
    assign gap_d  = gap_q + 8'd1;
    assign cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    // Broken sequences fall back to IDLE; F0 is a legal reset, not an error.
    always_ff @(negedge m2 or negedge not_reset) begin
        if (!not_reset) begin
            state_q <= S_IDLE;
            busy_q  <= '0;
            gap_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (state_q == S_BUSY) begin
                busy_q <= busy_d;
                if (busy_q <= 27'd1) state_q <= S_IDLE;
            end else if (!bus.prg_write_enabled) begin
                state_q <= S_IDLE;
                gap_q   <= '0;
            end else if (romw) begin
                gap_q <= '0;
                unique case (state_q)
                    S_IDLE: begin
                        if (a1 && d == 8'hAA) state_q <= S_U1;
                    end
                    S_U1: begin
                        if (a2 && d == 8'h55) begin
                            state_q <= S_U2;
                        end else begin
                            state_q <= S_IDLE;
                            err_q   <= ~f0;
                        end
                    end
                    S_U2: begin
                        if (a1 && d inside {8'hA0, 8'h80, 8'h90, 8'hF0}) begin
                            last_q <= d;
                            unique case (d)
                                8'hA0:   state_q <= S_PROG;
                                8'h80:   state_q <= S_E80;
                                8'h90:   state_q <= S_ID;
                                default: state_q <= S_IDLE;
                            endcase
                        end else begin
                            state_q <= S_IDLE;
                            err_q   <= ~f0;
                        end
                    end
                    S_PROG: begin
                        state_q <= S_BUSY;
                        busy_q  <= PROG_CYCLES;
                        cnt_q   <= cnt_d;
                    end
                    S_E80: begin
                        if (a1 && d == 8'hAA) begin
                            state_q <= S_EU1;
                        end else begin
                            state_q <= S_IDLE;
                            err_q   <= ~f0;
                        end
                    end
                    S_EU1: begin
                        if (a2 && d == 8'h55) begin
                            state_q <= S_EU2;
                        end else begin
                            state_q <= S_IDLE;
                            err_q   <= ~f0;
                        end
                    end
                    S_EU2: begin
                        if (d == 8'h30) begin
                            state_q <= S_BUSY;
                            busy_q  <= ERASE_CYCLES;
                            last_q  <= d;
                        end else if (a1 && d == 8'h10) begin
                            state_q <= S_BUSY;
                            busy_q  <= CHIP_ERASE_CYCLES;
                            last_q  <= d;
                        end else begin
                            state_q <= S_IDLE;
                            err_q   <= ~f0;
                        end
                    end
                    S_ID: begin
                        if (f0) state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (in_seq) begin
                gap_q <= gap_d;
                if (gap_d == GAP_CYCLES) begin
                    state_q <= S_IDLE;
                    gap_q   <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.flash_busy     = state_q == S_BUSY;
    assign bus.id_mode        = state_q == S_ID;
    assign bus.seq_error      = err_q;
    assign bus.last_cmd       = last_q;
    assign bus.prog_count     = cnt_q;
    // Writes are also blocked while the sequencer itself is held in reset.
    assign bus.flash_we_allow = not_reset & bus.prg_write_enabled &
                                (state_q != S_BUSY);

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Randomized and directed bench for flash_cmd_sequencer with a
// table-driven reference model of the JEDEC command rules.
module tb_flash_cmd_sequencer;

    localparam int PROG_N  = 40;
    localparam int ERASE_N = 100;
    localparam int CHIP_N  = 300;
    localparam int GAP_N   = 64;

    typedef struct packed {
        logic [14:0] a;
        logic [7:0]  d;
    } wr_t;

    logic m2 = 1'b1;
    logic not_reset = 1'b0;

    flash_cmd_sequencer_if bus();

    flash_cmd_sequencer #(
        .ERASE_CYCLES      (27'd100),
        .CHIP_ERASE_CYCLES (27'd300)
    ) dut (
        .m2        (m2),
        .not_reset (not_reset),
        .bus       (bus)
    );

    always #5 m2 = ~m2;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_seen;
    int err_seen;

    // Model: position in the unlock/command script plus mode flags.
    int         m_pos;
    bit         m_prog;
    bit         m_id;
    int         m_busy;
    int         m_gap;
    logic [7:0] m_last;
    int         m_cnt;
    bit         m_err;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic void m_idle();
        m_pos  = 0;
        m_prog = 0;
        m_id   = 0;
        m_gap  = 0;
    endfunction

    function automatic void model_reset();
        m_idle();
        m_busy = 0;
        m_last = 8'h00;
        m_cnt  = 0;
        m_err  = 0;
    endfunction

    function automatic void model_step(input bit romw, input logic [14:0] a,
                                       input logic [7:0] d, input bit pwe);
        bit a1;
        bit a2;
        bit ok;
        a1 = (a & 15'h0FFF) == 15'h0AAA;
        a2 = (a & 15'h0FFF) == 15'h0555;
        m_err = 0;
        if (m_busy > 0) begin
            m_busy--;
        end else if (!pwe) begin
            m_idle();
        end else if (m_id) begin
            if (romw && d == 8'hF0) m_id = 0;
        end else if (romw) begin
            m_gap = 0;
            if (m_prog) begin
                m_prog = 0;
                m_busy = PROG_N;
                if (m_cnt < 65535) m_cnt++;
            end else if (m_pos == 0) begin
                if (a1 && d == 8'hAA) m_pos = 1;
            end else begin
                if (m_pos == 1 || m_pos == 4) ok = a2 && d == 8'h55;
                else if (m_pos == 3) ok = a1 && d == 8'hAA;
                else if (m_pos == 2)
                    ok = a1 && d inside {8'hA0, 8'h80, 8'h90, 8'hF0};
                else ok = d == 8'h30 || (a1 && d == 8'h10);
                if (!ok) begin
                    m_err = d != 8'hF0;
                    m_idle();
                end else if (m_pos == 2) begin
                    m_last = d;
                    m_idle();
                    if (d == 8'hA0) m_prog = 1;
                    if (d == 8'h80) m_pos = 3;
                    if (d == 8'h90) m_id = 1;
                end else if (m_pos == 5) begin
                    m_last = d;
                    m_busy = (d == 8'h30) ? ERASE_N : CHIP_N;
                    m_idle();
                end else begin
                    m_pos++;
                end
            end
        end else if (m_pos > 0 || m_prog) begin
            m_gap++;
            if (m_gap == GAP_N) begin
                m_err = 1;
                m_idle();
            end
        end
    endfunction

    task automatic compare(input bit pwe);
        chk("busy", 32'(bus.flash_busy), 32'(m_busy > 0));
        chk("id_mode", 32'(bus.id_mode), 32'(m_id));
        chk("seq_error", 32'(bus.seq_error), 32'(m_err));
        chk("last_cmd", 32'(bus.last_cmd), 32'(m_last));
        chk("prog_count", 32'(bus.prog_count), 32'(m_cnt));
        chk("we_allow", 32'(bus.flash_we_allow),
            32'(pwe && m_busy == 0));
    endtask

    task automatic cyc(input bit rs, input bit rw, input logic [14:0] a,
                       input logic [7:0] d, input bit pwe);
        bus.romsel            = rs;
        bus.cpu_rw_in         = rw;
        bus.cpu_addr_in       = a;
        bus.cpu_data_in       = d;
        bus.prg_write_enabled = pwe;
        @(posedge m2);
        model_step(!rs && !rw, a, d, pwe);
        if (bus.flash_busy) busy_seen++;
        if (bus.seq_error) err_seen++;
        compare(pwe);
    endtask

    task automatic wr(input logic [14:0] a, input logic [7:0] d);
        cyc(1'b0, 1'b0, a, d, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 15'h0, 8'h00, 1'b1);
    endtask

    task automatic rnd_idle();
        int r;
        r = $urandom_range(0, 99);
        if (r < 50) cyc(1'b1, 1'($urandom), 15'($urandom), 8'($urandom), r != 0);
        else cyc(1'b0, 1'b1, 15'($urandom), 8'($urandom), 1'b1);
    endtask

    function automatic logic [14:0] ad1();
        return {3'($urandom), 12'hAAA};
    endfunction

    function automatic logic [14:0] ad2();
        return {3'($urandom), 12'h555};
    endfunction

    function automatic logic [7:0] rdat();
        logic [7:0] tbl [8];
        int i;
        tbl = '{8'hAA, 8'h55, 8'hA0, 8'h80, 8'h90, 8'hF0, 8'h30, 8'h10};
        i = $urandom_range(0, 8);
        return (i == 8) ? 8'($urandom) : tbl[i];
    endfunction

    function automatic logic [14:0] raddr();
        int i;
        i = $urandom_range(0, 2);
        return (i == 0) ? ad1() : (i == 1) ? ad2() : 15'($urandom);
    endfunction

    initial begin
        wr_t q[$];
        int  k;
        int  g;
        int  j;

        bus.romsel            = 1'b1;
        bus.cpu_rw_in         = 1'b1;
        bus.cpu_addr_in       = '0;
        bus.cpu_data_in       = '0;
        bus.prg_write_enabled = 1'b1;
        model_reset();
        #2;
        compare(1'b0);
        @(posedge m2);
        not_reset = 1'b1;
        idle(2);

        // Byte program: 40 busy cycles
        busy_seen = 0;
        wr(15'h0AAA, 8'hAA);
        wr(15'h0555, 8'h55);
        wr(15'h0AAA, 8'hA0);
        wr(15'h1234, 8'h5A);
        idle(60);
        chk("prog_busy_len", 32'(busy_seen), 32'd40);
        chk("prog_last", 32'(bus.last_cmd), 32'h0A0);
        chk("prog_cnt", 32'(bus.prog_count), 32'd1);

        // Sector erase with F0 on busy cycle 50
        wr(15'h0AAA, 8'hAA);
        wr(15'h0555, 8'h55);
        wr(15'h0AAA, 8'h80);
        wr(15'h0AAA, 8'hAA);
        wr(15'h0555, 8'h55);
        busy_seen = 0;
        wr(15'h4000, 8'h30);
        idle(48);
        wr(15'h0000, 8'hF0);
        idle(70);
        chk("erase_busy_len", 32'(busy_seen), 32'd100);
        chk("erase_last", 32'(bus.last_cmd), 32'h030);

        // Broken unlock and stray IDLE write
        err_seen = 0;
        wr(15'h0AAA, 8'hAA);
        wr(15'h0555, 8'h12);
        idle(1);
        wr(15'h0000, 8'h77);
        idle(1);
        chk("bad_unlock_err", 32'(err_seen), 32'd1);

        // Gap timeout
        err_seen = 0;
        wr(15'h0AAA, 8'hAA);
        idle(64);
        wr(15'h0555, 8'h55);
        wr(15'h0AAA, 8'hA0);
        wr(15'h0123, 8'h11);
        chk("gap_err", 32'(err_seen), 32'd1);
        chk("gap_no_busy", 32'(bus.flash_busy), 32'd0);

        // Autoselect
        wr(15'h0AAA, 8'hAA);
        wr(15'h0555, 8'h55);
        wr(15'h0AAA, 8'h90);
        wr(15'h0000, 8'h00);
        chk("id_hold", 32'(bus.id_mode), 32'd1);
        wr(15'h0000, 8'hF0);
        chk("id_exit", 32'(bus.id_mode), 32'd0);

        // Master write enable dropped mid-sequence
        err_seen = 0;
        wr(15'h0AAA, 8'hAA);
        wr(15'h0555, 8'h55);
        cyc(1'b1, 1'b1, 15'h0, 8'h00, 1'b0);
        chk("pwe_low_allow", 32'(bus.flash_we_allow), 32'd0);
        wr(15'h0AAA, 8'hA0);
        wr(15'h0AAA, 8'h33);
        chk("pwe_no_err", 32'(err_seen), 32'd0);

        // Randomized command scripts
        for (int s = 0; s < 120; s++) begin
            q.delete();
            k = $urandom_range(0, 5);
            if (k != 4) begin
                q.push_back('{ad1(), 8'hAA});
                q.push_back('{ad2(), 8'h55});
            end
            case (k)
                0: begin
                    q.push_back('{ad1(), 8'hA0});
                    q.push_back('{15'($urandom), 8'($urandom)});
                end
                1, 2: begin
                    q.push_back('{ad1(), 8'h80});
                    q.push_back('{ad1(), 8'hAA});
                    q.push_back('{ad2(), 8'h55});
                    if (k == 1) q.push_back('{15'($urandom), 8'h30});
                    else q.push_back('{ad1(), 8'h10});
                end
                3: begin
                    q.push_back('{ad1(), 8'h90});
                    q.push_back('{15'($urandom), rdat()});
                    q.push_back('{15'($urandom), 8'hF0});
                end
                4: begin
                    for (int i = 0; i < 3; i++) q.push_back('{raddr(), rdat()});
                end
                default: q.push_back('{ad1(), 8'hF0});
            endcase
            if ($urandom_range(0, 3) == 0) begin
                j = $urandom_range(0, q.size() - 1);
                q[j].d = rdat();
                q[j].a = raddr();
            end
            foreach (q[i]) begin
                if ($urandom_range(0, 19) == 0) g = $urandom_range(60, 70);
                else g = $urandom_range(0, 4);
                for (int c = 0; c < g; c++) rnd_idle();
                wr(q[i].a, q[i].d);
            end
            for (int c = 0; c < 400 && m_busy > 0; c++) rnd_idle();
        end

        // Reset in the middle of a program
        idle(2);
        wr(15'h0AAA, 8'hAA);
        wr(15'h0555, 8'h55);
        wr(15'h0AAA, 8'hA0);
        wr(15'h1234, 8'h01);
        idle(5);
        #2 not_reset = 1'b0;
        #1;
        model_reset();
        chk("rst_busy", 32'(bus.flash_busy), 32'd0);
        chk("rst_cnt", 32'(bus.prog_count), 32'd0);
        chk("rst_last", 32'(bus.last_cmd), 32'd0);
        chk("rst_allow", 32'(bus.flash_we_allow), 32'd0);
        @(posedge m2);
        not_reset = 1'b1;
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
